// File: rtl/modexp_sc_core.sv
// ============================================================================
// Module   : modexp_sc_core
// Brief    : Modular exponentiation engine, cypher = indata^inExp mod inMod,
//            with valid/ready handshakes, input reduction, a divide-by-zero
//            flag and data/timing secrecy labels.
//            Optional build macro: MODEXP_CONST_TIME_EN (constant-time mode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modexp_sc_core #(
  parameter int KEYSIZE = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KEYSIZE-1:0] indata,
  input  logic [KEYSIZE-1:0] inExp,
  input  logic [KEYSIZE-1:0] inMod,
  input  logic               indata_label,
  input  logic               inExp_label,
  input  logic               inMod_label,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KEYSIZE-1:0] cypher,
  output logic               cypher_label,
  output logic               err_mod0,
  output logic               timing_label
);

`ifdef MODEXP_CONST_TIME_EN
  localparam logic CONST_TIME = 1'b1;
`else
  localparam logic CONST_TIME = 1'b0;
`endif

  localparam int            IW  = $clog2(KEYSIZE);
  localparam logic [IW-1:0] KM1 = IW'(KEYSIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PRE  = 3'd2,
    S_SQR  = 3'd3,
    S_MUL  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_nx;

  // Latched request
  logic [KEYSIZE-1:0] base_q;
  logic [KEYSIZE-1:0] exp_q;
  logic [KEYSIZE-1:0] mod_q;
  logic               lab_d_q, lab_e_q, lab_m_q;

  // Working registers
  logic [KEYSIZE-1:0] acc_q;    // running exponentiation result
  logic [KEYSIZE-1:0] bred_q;   // base reduced mod inMod
  logic [KEYSIZE-1:0] r_q;      // partial remainder of the current step chain
  logic [IW-1:0]      idx_q;    // exponent bit being processed
  logic [IW-1:0]      cnt_q;    // step within the current KEYSIZE-cycle phase

  // Step datapath (KEYSIZE+2 bits so 2r+a < 3*mod never overflows)
  logic [KEYSIZE+1:0] mod_x, r_in, addend, r_dbl, r_s1, r_s2;
  logic               step_bit;
  logic               last_step;
  logic [KEYSIZE-1:0] step_res;
  logic [KEYSIZE-1:0] acc_fix;
  logic [IW-1:0]      msb_idx;
  logic               exp_zero;
  logic               mod_zero;
  logic               unused_hi;

  assign in_ready  = (state == S_IDLE);
  assign last_step = (cnt_q == '0);
  assign exp_zero  = (exp_q == '0);
  assign mod_zero  = (mod_q == '0);

  // One shift/add/reduce step shared by PRE (reduction), SQR and MUL
  always_comb begin
    mod_x  = {2'b00, mod_q};
    r_in   = (cnt_q == KM1) ? '0 : {2'b00, r_q};
    if (state == S_PRE) begin
      step_bit = base_q[cnt_q];
      addend   = {{(KEYSIZE+1){1'b0}}, 1'b1};
    end else begin
      step_bit = (state == S_MUL) ? bred_q[cnt_q] : acc_q[cnt_q];
      addend   = {2'b00, acc_q};
    end
    r_dbl    = {r_in[KEYSIZE:0], 1'b0} + (step_bit ? addend : '0);
    r_s1     = (r_dbl >= mod_x) ? (r_dbl - mod_x) : r_dbl;
    r_s2     = (r_s1 >= mod_x) ? (r_s1 - mod_x) : r_s1;
    step_res = r_s2[KEYSIZE-1:0];
  end

  // Remainder is always below the modulus, so the top two bits are zero
  assign unused_hi = &{1'b0, r_s2[KEYSIZE+1:KEYSIZE]};

  // Final fold: acc can only equal or exceed the modulus when inMod==1 and acc==1
  assign acc_fix = (acc_q >= mod_q) ? (acc_q - mod_q) : acc_q;

  // Position of the highest set exponent bit, used to skip leading zeros
  always_comb begin
    msb_idx = '0;
    for (int k = 0; k < KEYSIZE; k++) begin
      if (exp_q[k]) msb_idx = IW'(k);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) state_nx = S_LOAD;
      S_LOAD: state_nx = mod_zero ? S_DONE : S_PRE;
      S_PRE: begin
        if (last_step) state_nx = (!CONST_TIME && exp_zero) ? S_DONE : S_SQR;
      end
      S_SQR: begin
        if (last_step) begin
          if (CONST_TIME || exp_q[idx_q]) state_nx = S_MUL;
          else if (idx_q == '0)           state_nx = S_DONE;
          else                            state_nx = S_SQR;
        end
      end
      S_MUL: begin
        if (last_step) state_nx = (idx_q == '0) ? S_DONE : S_SQR;
      end
      S_DONE: if (out_valid && out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, step iteration and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q       <= '0;
      exp_q        <= '0;
      mod_q        <= '0;
      lab_d_q      <= 1'b0;
      lab_e_q      <= 1'b0;
      lab_m_q      <= 1'b0;
      acc_q        <= '0;
      bred_q       <= '0;
      r_q          <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      out_valid    <= 1'b0;
      cypher       <= '0;
      cypher_label <= 1'b0;
      err_mod0     <= 1'b0;
      timing_label <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            base_q  <= indata;
            exp_q   <= inExp;
            mod_q   <= inMod;
            lab_d_q <= indata_label;
            lab_e_q <= inExp_label;
            lab_m_q <= inMod_label;
          end
        end
        S_LOAD: begin
          acc_q <= KEYSIZE'(1);
          idx_q <= CONST_TIME ? KM1 : msb_idx;
          cnt_q <= KM1;
        end
        S_PRE, S_SQR, S_MUL: begin
          r_q   <= step_res;
          cnt_q <= last_step ? KM1 : (cnt_q - IW'(1));
          if (last_step) begin
            if (state == S_PRE) bred_q <= step_res;
            if (state == S_SQR) begin
              acc_q <= step_res;
              if (!CONST_TIME && !exp_q[idx_q]) idx_q <= idx_q - IW'(1);
            end
            if (state == S_MUL) begin
              if (exp_q[idx_q]) acc_q <= step_res;
              idx_q <= idx_q - IW'(1);
            end
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid    <= 1'b1;
            cypher       <= mod_zero ? '0 : acc_fix;
            err_mod0     <= mod_zero;
            cypher_label <= lab_d_q | lab_e_q | lab_m_q;
            timing_label <= CONST_TIME ? lab_m_q : (lab_e_q | lab_m_q);
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
